// File: rtl/wb_pkg.sv
// Shared types and helpers for the wb_pipe registered write-back stage.
// Optional feature macro used by wb_pipe: WB_BYPASS_EN.
package wb_pkg;

  // Widest datapath / index the shared entry struct can carry.
  localparam int WB_MAX_W  = 64;
  localparam int WB_MAX_AW = 8;

  typedef enum logic [2:0] {
    WB_PC   = 3'd0,
    WB_EX   = 3'd1,
    WB_MEM  = 3'd2,
    WB_IMM  = 3'd3,
    WB_BTR  = 3'd4,
    WB_SLBI = 3'd5
  } wb_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                 wen;
    logic [WB_MAX_AW-1:0] rd;
    logic [WB_MAX_W-1:0]  data;
  } wb_entry_t;

  // Reverses the low w bits of v; bits at or above w must be zero.
  function automatic logic [WB_MAX_W-1:0] bitrev(input logic [WB_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [WB_MAX_W-1:0] r;
    for (int i = 0; i < WB_MAX_W; i++) r[i] = v[WB_MAX_W-1-i];
    return r >> (WB_MAX_W - w);
  endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Combinational write-back value select; legal=0 flags a reserved mode code.
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   mode,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] ex,
  input  logic [W-1:0] mem,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] rs,
  output logic         legal,
  output logic [W-1:0] data
);

  always_comb begin
    legal = 1'b1;
    data  = '0;
    case (mode)
      WB_PC:   data = pc;
      WB_EX:   data = ex;
      WB_MEM:  data = mem;
      WB_IMM:  data = imm;
      WB_BTR:  data = W'(bitrev(WB_MAX_W'(rs), W));
      WB_SLBI: data = {rs[W/2-1:0], imm[W/2-1:0]};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_pipe.sv
// Registered write-back stage: result select, two-entry elastic buffer, retire counter.
// Define WB_BYPASS_EN to expose the pending-write bypass ports.
module wb_pipe
  import wb_pkg::*;
#(
  parameter  int W    = 16,
  parameter  int REGS = 8,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_mode,
  input  logic          in_wen,
  input  logic [AW-1:0] in_rd,
  input  logic [W-1:0]  in_pc,
  input  logic [W-1:0]  in_ex,
  input  logic [W-1:0]  in_mem,
  input  logic [W-1:0]  in_imm,
  input  logic [W-1:0]  in_rs,
  output logic          rf_wen,
  output logic [AW-1:0] rf_rd,
  output logic [W-1:0]  rf_data,
  input  logic          rf_ready,
  output logic [15:0]   retire_cnt,
`ifdef WB_BYPASS_EN
  output logic          byp0_valid,
  output logic [AW-1:0] byp0_rd,
  output logic [W-1:0]  byp0_data,
  output logic          byp1_valid,
  output logic [AW-1:0] byp1_rd,
  output logic [W-1:0]  byp1_data,
`endif
  output wb_state_t     dbg_state
);

  // Handshake: an entry transfers in on in_valid && in_ready; a write transfers out
  // on rf_wen && rf_ready. rf_* hold steady until then; wen=0 entries leave without rf_ready.

  logic         mux_legal;
  logic [W-1:0] mux_data;

  wb_result_mux #(.W(W)) u_mux (
    .mode  (in_mode),
    .pc    (in_pc),
    .ex    (in_ex),
    .mem   (in_mem),
    .imm   (in_imm),
    .rs    (in_rs),
    .legal (mux_legal),
    .data  (mux_data)
  );

  wb_entry_t new_e, main_q, main_d, skid_q, skid_d;
  wb_state_t state_q, state_d;
  logic      in_ready_q;
  logic [15:0] retire_q;
  logic      accept, drain, main_valid, skid_valid;

  always_comb begin
    new_e      = '0;
    new_e.wen  = in_wen && mux_legal;
    new_e.rd   = WB_MAX_AW'(in_rd);
    new_e.data = WB_MAX_W'(mux_data);
  end

  assign main_valid = (state_q != ST_EMPTY);
  assign skid_valid = (state_q == ST_TWO);
  assign accept     = in_valid && in_ready_q;
  assign drain      = main_valid && (rf_ready || !main_q.wen);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = new_e;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_d = new_e;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = new_e;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered from next state so in_ready never sees an input combinationally.
      in_ready_q <= (state_d != ST_TWO);
      if (rf_wen && rf_ready) retire_q <= retire_q + 16'd1;
    end
  end

  assign in_ready   = in_ready_q;
  assign rf_wen     = main_valid && main_q.wen;
  assign rf_rd      = main_valid ? main_q.rd[AW-1:0] : '0;
  assign rf_data    = main_valid ? main_q.data[W-1:0] : '0;
  assign retire_cnt = retire_q;
  assign dbg_state  = state_q;

  // Upper struct bits are always zero for this configuration.
  logic unused_hi;
  assign unused_hi = ^{main_q.data >> W, main_q.rd >> AW};

`ifdef WB_BYPASS_EN
  assign byp0_valid = rf_wen;
  assign byp0_rd    = rf_rd;
  assign byp0_data  = rf_data;
  assign byp1_valid = skid_valid && skid_q.wen;
  assign byp1_rd    = skid_valid ? skid_q.rd[AW-1:0] : '0;
  assign byp1_data  = skid_valid ? skid_q.data[W-1:0] : '0;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: queue-based reference model plus write scoreboard.
// Bypass checks are compiled in when WB_BYPASS_EN is defined.
module tb_wb_pipe;
  import wb_pkg::*;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_wen, rf_wen, rf_ready;
  logic [2:0]    in_mode;
  logic [AW-1:0] in_rd, rf_rd;
  logic [W-1:0]  in_pc, in_ex, in_mem, in_imm, in_rs, rf_data;
  logic [15:0]   retire_cnt;
  wb_state_t     dbg_state;
`ifdef WB_BYPASS_EN
  logic          byp0_valid, byp1_valid;
  logic [AW-1:0] byp0_rd, byp1_rd;
  logic [W-1:0]  byp0_data, byp1_data;
`endif

  wb_pipe #(.W(W), .REGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_wen     (in_wen),
    .in_rd      (in_rd),
    .in_pc      (in_pc),
    .in_ex      (in_ex),
    .in_mem     (in_mem),
    .in_imm     (in_imm),
    .in_rs      (in_rs),
    .rf_wen     (rf_wen),
    .rf_rd      (rf_rd),
    .rf_data    (rf_data),
    .rf_ready   (rf_ready),
    .retire_cnt (retire_cnt),
`ifdef WB_BYPASS_EN
    .byp0_valid (byp0_valid),
    .byp0_rd    (byp0_rd),
    .byp0_data  (byp0_data),
    .byp1_valid (byp1_valid),
    .byp1_rd    (byp1_rd),
    .byp1_data  (byp1_data),
`endif
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } ent_t;

  ent_t                mq[$];
  logic [AW+W-1:0]     exp_q[$];
  logic [15:0]         m_retire;
  int                  n_vec = 0;
  int                  n_err = 0;

  function automatic ent_t ref_entry(input logic [2:0] mode, input logic wen,
                                     input logic [AW-1:0] rd, input logic [W-1:0] pc,
                                     input logic [W-1:0] ex, input logic [W-1:0] mem,
                                     input logic [W-1:0] imm, input logic [W-1:0] rs);
    ent_t e;
    e.wen  = wen;
    e.rd   = rd;
    e.data = '0;
    case (mode)
      3'd0: e.data = pc;
      3'd1: e.data = ex;
      3'd2: e.data = mem;
      3'd3: e.data = imm;
      3'd4: for (int i = 0; i < W; i++) e.data[W-1-i] = rs[i];
      3'd5: e.data = {rs[W/2-1:0], imm[W/2-1:0]};
      default: e.wen = 1'b0;
    endcase
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [2:0] mode, input logic wen,
                        input logic [AW-1:0] rd, input logic rdy);
    in_valid = v;
    in_mode  = mode;
    in_wen   = wen;
    in_rd    = rd;
    rf_ready = rdy;
    in_pc    = 16'($urandom);
    in_ex    = 16'($urandom);
    in_mem   = 16'($urandom);
    in_imm   = 16'($urandom);
    in_rs    = 16'($urandom);
  endtask

  // Advance one clock, updating the reference queue from the inputs now applied.
  task automatic tick();
    ent_t e;
    logic acc, drn;
    e   = ref_entry(in_mode, in_wen, in_rd, in_pc, in_ex, in_mem, in_imm, in_rs);
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && (rf_ready || !mq[0].wen);
    if (drn && mq[0].wen) m_retire = m_retire + 16'd1;
    if (acc && e.wen) exp_q.push_back({e.rd, e.data});
    @(posedge clk);
    #1;
    if (drn) void'(mq.pop_front());
    if (acc) mq.push_back(e);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    rf_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    exp_q.delete();
    m_retire = '0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 3'd1, 1'b0, '0, 1'b1);
      @(negedge clk);
      tick();
    end
  endtask

  // Write scoreboard: every completed register write must match the oldest expected one.
  always @(negedge clk) begin
    logic [AW+W-1:0] exp_w;
    if (rst_n === 1'b1 && rf_wen === 1'b1 && rf_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_write: got rd=%0d data=%h, required no write", rf_rd, rf_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rf_rd, rf_data} !== exp_w) begin
          n_err++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_data, exp_w[AW+W-1:W], exp_w[W-1:0]);
        end
      end
    end
  end

  task automatic test_reset();
    set_in(1'b0, 3'd0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rst_rf_wen: got %b required 0", rf_wen); end
    n_vec++; if (rf_rd !== '0) begin n_err++; $display("FAIL rst_rf_rd: got %0d required 0", rf_rd); end
    n_vec++; if (rf_data !== '0) begin n_err++; $display("FAIL rst_rf_data: got %h required 0", rf_data); end
    n_vec++; if (retire_cnt !== 16'd0) begin n_err++; $display("FAIL rst_retire: got %0d required 0", retire_cnt); end
    n_vec++; if (dbg_state !== ST_EMPTY) begin n_err++; $display("FAIL rst_state: got %0d required EMPTY", dbg_state); end
`ifdef WB_BYPASS_EN
    n_vec++;
    if ({byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data} !== '0) begin
      n_err++; $display("FAIL rst_bypass: got nonzero, required all 0");
    end
`endif
    tick();
  endtask

  task automatic test_mode_sweep();
    logic [2:0]   modes[4] = '{3'd4, 3'd5, 3'd3, 3'd6};
    logic [W-1:0] exps[4]  = '{16'h8000, 16'h01AB, 16'h00AB, 16'h0000};
    logic [W-1:0] pick;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, modes[k], 1'b1, AW'($urandom), 1'b1);
      in_rs  = 16'h0001;
      in_imm = 16'h00AB;
      @(negedge clk);
      tick();
      set_in(1'b0, 3'd0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (modes[k] == 3'd6) begin
        n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL mode6_wen: got %b required 0", rf_wen); end
        n_vec++; if (retire_cnt !== m_retire) begin n_err++; $display("FAIL mode6_retire: got %0d required %0d", retire_cnt, m_retire); end
      end else begin
        n_vec++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL mode%0d_wen: got %b required 1", modes[k], rf_wen); end
        n_vec++; if (rf_data !== exps[k]) begin n_err++; $display("FAIL mode%0d_data: got %h required %h", modes[k], rf_data, exps[k]); end
      end
      tick();
    end
    for (int m = 0; m < 3; m++) begin
      set_in(1'b1, 3'(m), 1'b1, AW'($urandom), 1'b1);
      pick = (m == 0) ? in_pc : (m == 1) ? in_ex : in_mem;
      @(negedge clk);
      tick();
      set_in(1'b0, 3'd0, 1'b0, '0, 1'b1);
      @(negedge clk);
      n_vec++; if (rf_data !== pick) begin n_err++; $display("FAIL mode%0d_data: got %h required %h", m, rf_data, pick); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d[4];
    logic [15:0]  r0;
    r0 = m_retire;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        set_in(1'b1, 3'd1, 1'b1, AW'(c), 1'b1);
        d[c] = in_ex;
      end else begin
        set_in(1'b0, 3'd1, 1'b0, '0, 1'b1);
      end
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b required 1", c, in_ready); end
      if (c > 0) begin
        n_vec++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL b2b_wen c%0d: got %b required 1", c, rf_wen); end
        n_vec++; if (rf_data !== d[c-1]) begin n_err++; $display("FAIL b2b_data c%0d: got %h required %h", c, rf_data, d[c-1]); end
      end
      tick();
    end
    set_in(1'b0, 3'd1, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (retire_cnt !== r0 + 16'd4) begin n_err++; $display("FAIL b2b_retire: got %0d required %0d", retire_cnt, r0 + 16'd4); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] da, db;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 3'd2, 1'b1, AW'(c + 1), 1'b0);
      if (c == 0) da = in_mem;
      if (c == 1) db = in_mem;
      @(negedge clk);
      if (c == 2) begin
        n_vec++; if (dbg_state !== ST_TWO) begin n_err++; $display("FAIL bp_state: got %0d required TWO", dbg_state); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b required 0", in_ready); end
      end
      tick();
    end
    set_in(1'b0, 3'd2, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (rf_data !== da) begin n_err++; $display("FAIL bp_first: got %h required %h", rf_data, da); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_drain: got %b required 0", in_ready); end
    tick();
    set_in(1'b0, 3'd2, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (rf_data !== db) begin n_err++; $display("FAIL bp_second: got %h required %h", rf_data, db); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b required 1", in_ready); end
    tick();
    set_in(1'b0, 3'd2, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL bp_empty_wen: got %b required 0", rf_wen); end
    tick();
  endtask

  task automatic test_wen0_ahead();
    logic [W-1:0] dw;
    set_in(1'b1, 3'd1, 1'b0, 3'd5, 1'b0);
    @(negedge clk);
    tick();
    set_in(1'b1, 3'd1, 1'b1, 3'd6, 1'b0);
    dw = in_ex;
    @(negedge clk);
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL w0_head_wen: got %b required 0", rf_wen); end
    tick();
    set_in(1'b0, 3'd1, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (rf_wen !== 1'b1) begin n_err++; $display("FAIL w0_wait_wen: got %b required 1", rf_wen); end
    n_vec++; if (rf_data !== dw) begin n_err++; $display("FAIL w0_wait_data: got %h required %h", rf_data, dw); end
    n_vec++; if (dbg_state !== ST_ONE) begin n_err++; $display("FAIL w0_state: got %0d required ONE", dbg_state); end
    tick();
    drain_all();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    logic [W-1:0] da, db;
    set_in(1'b1, 3'd1, 1'b1, 3'd3, 1'b0);
    da = in_ex;
    @(negedge clk);
    tick();
    set_in(1'b1, 3'd1, 1'b1, 3'd3, 1'b0);
    db = in_ex;
    @(negedge clk);
    tick();
    set_in(1'b0, 3'd1, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (byp1_valid !== 1'b1 || byp1_rd !== 3'd3 || byp1_data !== db) begin
      n_err++; $display("FAIL byp1_two: got v=%b rd=%0d d=%h required v=1 rd=3 d=%h", byp1_valid, byp1_rd, byp1_data, db); end
    n_vec++; if (byp0_valid !== 1'b1 || byp0_data !== da) begin
      n_err++; $display("FAIL byp0_two: got v=%b d=%h required v=1 d=%h", byp0_valid, byp0_data, da); end
    tick();
    set_in(1'b0, 3'd1, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_vec++; if (byp0_valid !== 1'b1 || byp0_data !== db) begin
      n_err++; $display("FAIL byp0_after: got v=%b d=%h required v=1 d=%h", byp0_valid, byp0_data, db); end
    n_vec++; if (byp1_valid !== 1'b0) begin n_err++; $display("FAIL byp1_after: got %b required 0", byp1_valid); end
    tick();
    drain_all();
  endtask
`endif

  task automatic test_reset_in_two();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 3'd0, 1'b1, AW'(c), 1'b0);
      @(negedge clk);
      tick();
    end
    do_reset();
    set_in(1'b0, 3'd0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rst2_wen: got %b required 0", rf_wen); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst2_ready: got %b required 1", in_ready); end
    n_vec++; if (retire_cnt !== 16'd0) begin n_err++; $display("FAIL rst2_retire: got %0d required 0", retire_cnt); end
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 3'd0, 1'b0, '0, 1'b1);
      @(negedge clk);
      n_vec++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL rst2_stale c%0d: got %b required 0", c, rf_wen); end
      tick();
    end
  endtask

  task automatic test_random();
    ent_t      h;
    wb_state_t es;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             AW'($urandom), $urandom_range(0, 9) < 6);
      @(negedge clk);
      h  = (mq.size() > 0) ? mq[0] : '0;
      es = (mq.size() == 0) ? ST_EMPTY : (mq.size() == 1) ? ST_ONE : ST_TWO;
      n_vec++; if (in_ready !== (mq.size() < 2)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b required %b", c, in_ready, mq.size() < 2); end
      n_vec++; if (rf_wen !== h.wen) begin n_err++; $display("FAIL rnd_wen c%0d: got %b required %b", c, rf_wen, h.wen); end
      n_vec++; if (rf_rd !== h.rd) begin n_err++; $display("FAIL rnd_rd c%0d: got %0d required %0d", c, rf_rd, h.rd); end
      n_vec++; if (rf_data !== h.data) begin n_err++; $display("FAIL rnd_data c%0d: got %h required %h", c, rf_data, h.data); end
      n_vec++; if (retire_cnt !== m_retire) begin n_err++; $display("FAIL rnd_retire c%0d: got %0d required %0d", c, retire_cnt, m_retire); end
      n_vec++; if (dbg_state !== es) begin n_err++; $display("FAIL rnd_state c%0d: got %0d required %0d", c, dbg_state, es); end
`ifdef WB_BYPASS_EN
      h = (mq.size() > 1) ? mq[1] : '0;
      n_vec++; if ({byp1_valid, byp1_rd, byp1_data} !== {h.wen, h.rd, h.data}) begin
        n_err++; $display("FAIL rnd_byp1 c%0d: got v=%b rd=%0d d=%h required v=%b rd=%0d d=%h",
                          c, byp1_valid, byp1_rd, byp1_data, h.wen, h.rd, h.data); end
`endif
      tick();
    end
    drain_all();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 3'd0, 1'b0, '0, 1'b0);
    m_retire = '0;
    do_reset();
    test_reset();
    test_mode_sweep();
    test_back_to_back();
    test_back_pressure();
    test_wen0_ahead();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_in_two();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d writes never completed, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
